// File: rtl/commit_unit.sv
// commit_unit: retires the ROB head. Register-writing ops and branches retire
// in the cycle they are presented. Stores are held in STORE until memory
// completes. A mispredicted branch or JALR triggers a one-cycle FLUSH with a
// registered redirect PC. Retirement and mispredict counters are kept here.
module commit_unit #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int OP_WIDTH     = 6,
  parameter int XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit_valid,
  input  logic [ROB_ID_WIDTH-1:0] commit_id,
  input  logic [OP_WIDTH-1:0]     commit_op,
  input  logic [4:0]              commit_rd,
  input  logic [XLEN-1:0]         commit_value,
  input  logic [XLEN-1:0]         commit_pc,
  input  logic [XLEN-1:0]         commit_addr,
  input  logic [XLEN-1:0]         commit_pred_target,
  input  logic                    commit_pred,
  input  logic                    commit_outcome,
  output logic                    commit_ack,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [ROB_ID_WIDTH-1:0] rf_wrob_id,
  output logic                    mem_req,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [3:0]              mem_wmask,
  input  logic                    mem_done,
  output logic                    flush,
  output logic [XLEN-1:0]         redirect_pc,
  output logic [31:0]             instret_cnt,
  output logic [31:0]             mispredict_cnt
);

  // Shared op encodings (must match the decoder's op table).
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(24);
  localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(25);
  localparam logic [OP_WIDTH-1:0] OP_BLT  = OP_WIDTH'(26);
  localparam logic [OP_WIDTH-1:0] OP_BGE  = OP_WIDTH'(27);
  localparam logic [OP_WIDTH-1:0] OP_BLTU = OP_WIDTH'(28);
  localparam logic [OP_WIDTH-1:0] OP_BGEU = OP_WIDTH'(29);
  localparam logic [OP_WIDTH-1:0] OP_SB   = OP_WIDTH'(32);
  localparam logic [OP_WIDTH-1:0] OP_SH   = OP_WIDTH'(33);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(34);
  localparam logic [OP_WIDTH-1:0] OP_JALR = OP_WIDTH'(40);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [3:0]        mem_wmask_q;
  logic              flush_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic [31:0]       instret_q;
  logic [31:0]       mispredict_q;

  logic              is_branch_s;
  logic              is_store_s;
  logic              is_jalr_s;
  logic              mispred_s;
  logic              ack_s;
  logic              mispred_ack_s;
  logic [XLEN-1:0]   wdata_d;
  logic [3:0]        wmask_d;
  logic [XLEN-1:0]   redirect_d;

  // Classify the head op and decide whether its prediction was wrong.
  always_comb begin
    is_branch_s = (commit_op == OP_BEQ)  || (commit_op == OP_BNE)  ||
                  (commit_op == OP_BLT)  || (commit_op == OP_BGE)  ||
                  (commit_op == OP_BLTU) || (commit_op == OP_BGEU);
    is_store_s  = (commit_op == OP_SB) || (commit_op == OP_SH) || (commit_op == OP_SW);
    is_jalr_s   = (commit_op == OP_JALR);
    if (is_branch_s) begin
      mispred_s = (commit_pred != commit_outcome) ||
                  (commit_outcome && (commit_pred_target != commit_addr));
    end else if (is_jalr_s) begin
      mispred_s = !commit_pred || (commit_pred_target != commit_addr);
    end else begin
      mispred_s = 1'b0;
    end
    // JALR always redirects to its computed target; branches only when taken.
    if (is_jalr_s || commit_outcome) begin
      redirect_d = commit_addr;
    end else begin
      redirect_d = commit_pc + XLEN'(4);
    end
  end

  // Same-cycle retire handshake and register-file write port.
  always_comb begin
    if (rst) begin
      ack_s = 1'b0;
    end else begin
      case (state_q)
        IDLE:    ack_s = commit_valid && !is_store_s;
        STORE:   ack_s = mem_done;
        FLUSH:   ack_s = 1'b0;
        default: ack_s = 1'b0;
      endcase
    end
    mispred_ack_s = ack_s && mispred_s;
    rf_we         = ack_s && !is_branch_s && !is_store_s && (commit_rd != 5'd0);
  end

  // Lane-align store data and byte mask from the low address bits.
  always_comb begin
    case (commit_op)
      OP_SW: begin
        wmask_d = 4'b1111;
        wdata_d = commit_value;
      end
      OP_SH: begin
        wmask_d = 4'b0011 << {commit_addr[1], 1'b0};
        wdata_d = commit_value << {commit_addr[1], 4'b0000};
      end
      OP_SB: begin
        wmask_d = 4'b0001 << commit_addr[1:0];
        wdata_d = commit_value << {commit_addr[1:0], 3'b000};
      end
      default: begin
        wmask_d = 4'b0000;
        wdata_d = {XLEN{1'b0}};
      end
    endcase
  end

  // Control FSM with registered store, flush and statistics outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= {XLEN{1'b0}};
      mem_wdata_q   <= {XLEN{1'b0}};
      mem_wmask_q   <= 4'b0000;
      flush_q       <= 1'b0;
      redirect_pc_q <= {XLEN{1'b0}};
      instret_q     <= 32'd0;
      mispredict_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (commit_valid && is_store_s) begin
            state_q     <= STORE;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= commit_addr;
            mem_wdata_q <= wdata_d;
            mem_wmask_q <= wmask_d;
          end else if (mispred_ack_s) begin
            state_q       <= FLUSH;
            flush_q       <= 1'b1;
            redirect_pc_q <= redirect_d;
          end else begin
            state_q <= IDLE;
          end
        end
        STORE: begin
          if (mem_done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else begin
            state_q <= STORE;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          flush_q   <= 1'b0;
        end
      endcase
      instret_q    <= instret_q + {31'd0, ack_s};
      mispredict_q <= mispredict_q + {31'd0, mispred_ack_s};
    end
  end

  assign commit_ack     = ack_s;
  assign rf_waddr       = commit_rd;
  assign rf_wdata       = commit_value;
  assign rf_wrob_id     = commit_id;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign instret_cnt    = instret_q;
  assign mispredict_cnt = mispredict_q;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed vector table, hand-written
// reset sequences and a randomized instruction stream against a
// transaction-level model of the retire rules.
module tb_commit_unit;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd16;
  localparam logic [5:0] OP_BEQ  = 6'd24;
  localparam logic [5:0] OP_BNE  = 6'd25;
  localparam logic [5:0] OP_BLT  = 6'd26;
  localparam logic [5:0] OP_BGE  = 6'd27;
  localparam logic [5:0] OP_BLTU = 6'd28;
  localparam logic [5:0] OP_BGEU = 6'd29;
  localparam logic [5:0] OP_SB   = 6'd32;
  localparam logic [5:0] OP_SH   = 6'd33;
  localparam logic [5:0] OP_SW   = 6'd34;
  localparam logic [5:0] OP_JALR = 6'd40;
  localparam logic [5:0] OP_JAL  = 6'd41;

  logic        clk, rst, commit_valid, commit_pred, commit_outcome;
  logic [3:0]  commit_id;
  logic [5:0]  commit_op;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, commit_pc, commit_addr, commit_pred_target;
  logic        commit_ack, rf_we, mem_req, mem_done, flush;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, mem_addr, mem_wdata, redirect_pc, instret_cnt, mispredict_cnt;
  logic [3:0]  rf_wrob_id, mem_wmask;

  commit_unit dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_op(commit_op), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_pc(commit_pc), .commit_addr(commit_addr),
    .commit_pred_target(commit_pred_target), .commit_pred(commit_pred),
    .commit_outcome(commit_outcome), .commit_ack(commit_ack), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wrob_id(rf_wrob_id),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_done(mem_done), .flush(flush),
    .redirect_pc(redirect_pc), .instret_cnt(instret_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [3:0]  id;
    logic [31:0] pc, addr, ptgt;
    logic        pred, outcome;
    int          delay;
    logic        exp_store, exp_we, exp_flush;
    logic [31:0] exp_redirect;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_instret = 32'd0;
  logic [31:0] m_mispred = 32'd0;
  logic [31:0] m_redirect = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [5:0] op, input logic [4:0] rd,
      input logic [31:0] value, input logic [3:0] id, input logic [31:0] pc,
      input logic [31:0] addr, input logic [31:0] ptgt, input logic pred,
      input logic outcome, input int delay, input logic st, input logic we,
      input logic fl, input logic [31:0] redir, input logic [3:0] mask,
      input logic [31:0] wdata);
    vec_t v;
    v.op = op; v.rd = rd; v.value = value; v.id = id; v.pc = pc; v.addr = addr;
    v.ptgt = ptgt; v.pred = pred; v.outcome = outcome; v.delay = delay;
    v.exp_store = st; v.exp_we = we; v.exp_flush = fl; v.exp_redirect = redir;
    v.exp_mask = mask; v.exp_wdata = wdata;
    return v;
  endfunction

  // Random instruction with expectations derived from the retire rules.
  function automatic vec_t gen();
    vec_t v;
    int kind, off, nbytes;
    logic [63:0] wide;
    logic [5:0] reg_ops [4];
    reg_ops[0] = OP_ADD; reg_ops[1] = 6'd1; reg_ops[2] = OP_LW; reg_ops[3] = OP_JAL;
    v = mkv(OP_ADD, 5'($urandom_range(0, 31)), $urandom, 4'($urandom), $urandom & 32'hFFFF_FFFC,
            $urandom, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    v.ptgt = ($urandom_range(0, 1) == 0) ? v.addr : $urandom;
    v.pred = 1'($urandom);
    v.outcome = 1'($urandom);
    kind = $urandom_range(0, 3);
    if (kind == 0) begin
      v.op = reg_ops[$urandom_range(0, 3)];
      v.exp_we = (v.rd != 5'd0);
    end else if (kind == 1) begin
      v.op = OP_BEQ + 6'($urandom_range(0, 5));
      v.exp_flush = (v.pred != v.outcome) || (v.outcome && v.ptgt != v.addr);
      v.exp_redirect = v.outcome ? v.addr : v.pc + 32'd4;
    end else if (kind == 2) begin
      v.op = OP_JALR;
      v.pred = ($urandom_range(0, 3) != 0);
      v.exp_we = (v.rd != 5'd0);
      v.exp_flush = !v.pred || (v.ptgt != v.addr);
      v.exp_redirect = v.addr;
    end else begin
      v.exp_store = 1'b1;
      v.delay = $urandom_range(1, 4);
      case ($urandom_range(0, 2))
        0: begin v.op = OP_SB; nbytes = 1; off = int'(v.addr % 4); end
        1: begin v.op = OP_SH; nbytes = 2; off = (int'(v.addr % 4) / 2) * 2; end
        default: begin v.op = OP_SW; nbytes = 4; off = 0; end
      endcase
      v.exp_mask = 4'(((1 << nbytes) - 1) << off);
      wide = {32'd0, v.value} << (8 * off);
      v.exp_wdata = wide[31:0];
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    commit_valid = 1'b1; commit_op = v.op; commit_rd = v.rd; commit_value = v.value;
    commit_id = v.id; commit_pc = v.pc; commit_addr = v.addr;
    commit_pred_target = v.ptgt; commit_pred = v.pred; commit_outcome = v.outcome;
  endtask

  // Present one head entry, follow it to retirement and check every step.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    mem_done = 1'b0;
    #4;
    if (v.exp_store) begin
      chk({tag, " issue ack"}, commit_ack, 0);
      chk({tag, " issue rf_we"}, rf_we, 0);
      tick();
      for (int i = 1; i <= v.delay; i++) begin
        if (i == v.delay) mem_done = 1'b1;
        chk({tag, " mem_req"}, mem_req, 1);
        chk({tag, " mem_addr"}, mem_addr, v.addr);
        chk({tag, " mem_wmask"}, mem_wmask, v.exp_mask);
        chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
        #4;
        chk({tag, " store ack"}, commit_ack, (i == v.delay));
        chk({tag, " store rf_we"}, rf_we, 0);
        if (i == v.delay) m_instret++;
        tick();
      end
      mem_done = 1'b0;
      commit_valid = 1'b0;
      chk({tag, " mem_req drop"}, mem_req, 0);
    end else begin
      chk({tag, " ack"}, commit_ack, 1);
      chk({tag, " rf_we"}, rf_we, v.exp_we);
      if (v.exp_we) begin
        chk({tag, " rf_waddr"}, rf_waddr, v.rd);
        chk({tag, " rf_wdata"}, rf_wdata, v.value);
        chk({tag, " rf_wrob_id"}, rf_wrob_id, v.id);
      end
      m_instret++;
      if (v.exp_flush) begin
        m_mispred++;
        m_redirect = v.exp_redirect;
      end
      tick();
      commit_op = OP_ADD;
      commit_rd = 5'd7;
      chk({tag, " flush"}, flush, v.exp_flush);
      if (v.exp_flush) begin
        #4;
        chk({tag, " flush-cycle ack"}, commit_ack, 0);
        chk({tag, " flush-cycle rf_we"}, rf_we, 0);
        tick();
        chk({tag, " flush end"}, flush, 0);
      end
      commit_valid = 1'b0;
    end
    chk({tag, " redirect_pc"}, redirect_pc, m_redirect);
    chk({tag, " instret_cnt"}, instret_cnt, m_instret);
    chk({tag, " mispredict_cnt"}, mispredict_cnt, m_mispred);
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = mkv(OP_ADD,  5'd5,  32'h1234,     4'd3, 32'h0,        32'h0,    32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0,    32'h0);
    tbl[1]  = mkv(OP_ADD,  5'd0,  32'h55,       4'd1, 32'h4,        32'h0,    32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0,    32'h0);
    tbl[2]  = mkv(OP_SB,   5'd0,  32'hAB,       4'd2, 32'h8,        32'h1002, 32'h0,    1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 32'h0,   4'b0100, 32'h00AB0000);
    tbl[3]  = mkv(OP_BEQ,  5'd3,  32'h9,        4'd2, 32'h100,      32'h140,  32'h0,    1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 32'h140, 4'h0,    32'h0);
    tbl[4]  = mkv(OP_JALR, 5'd1,  32'h204,      4'd5, 32'h200,      32'h310,  32'h300,  1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 32'h310, 4'h0,    32'h0);
    tbl[5]  = mkv(OP_BNE,  5'd0,  32'h0,        4'd6, 32'h400,      32'h480,  32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0,    32'h0);
    tbl[6]  = mkv(OP_BLT,  5'd0,  32'h0,        4'd7, 32'h500,      32'h520,  32'h520,  1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h504, 4'h0,    32'h0);
    tbl[7]  = mkv(OP_BGEU, 5'd0,  32'h0,        4'd8, 32'h600,      32'h644,  32'h640,  1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 32'h644, 4'h0,    32'h0);
    tbl[8]  = mkv(OP_BLTU, 5'd0,  32'h0,        4'd9, 32'h700,      32'h780,  32'h780,  1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0,    32'h0);
    tbl[9]  = mkv(OP_JALR, 5'd2,  32'h804,      4'hA, 32'h800,      32'h900,  32'h900,  1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0,    32'h0);
    tbl[10] = mkv(OP_JALR, 5'd0,  32'h0,        4'hB, 32'h900,      32'hA00,  32'hA00,  1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 32'hA00, 4'h0,    32'h0);
    tbl[11] = mkv(OP_BGE,  5'd0,  32'h0,        4'hC, 32'hFFFFFFFC, 32'h10,   32'h10,   1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0,   4'h0,    32'h0);
    tbl[12] = mkv(OP_SH,   5'd0,  32'h1234BEEF, 4'hD, 32'h0,        32'h2002, 32'h0,    1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0,   4'b1100, 32'hBEEF0000);
    tbl[13] = mkv(OP_SW,   5'd0,  32'hDEADBEEF, 4'hE, 32'h0,        32'h3000, 32'h0,    1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 32'h0,   4'b1111, 32'hDEADBEEF);
    tbl[14] = mkv(OP_SB,   5'd0,  32'h12345678, 4'hF, 32'h0,        32'h3003, 32'h0,    1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0,   4'b1000, 32'h78000000);
    tbl[15] = mkv(OP_SH,   5'd0,  32'hCAFE,     4'h0, 32'h0,        32'h3000, 32'h0,    1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 32'h0,   4'b0011, 32'h0000CAFE);
    tbl[16] = mkv(OP_LW,   5'd31, 32'hFEED,     4'h4, 32'h0,        32'h0,    32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0,    32'h0);

    // Reset overrides a valid head and a stray mem_done.
    rst = 1'b1; mem_done = 1'b1;
    drive(tbl[0]);
    tick();
    #4;
    chk("reset ack", commit_ack, 0);
    chk("reset rf_we", rf_we, 0);
    tick();
    rst = 1'b0; commit_valid = 1'b0;
    chk("reset mem_req", mem_req, 0);
    chk("reset flush", flush, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset mem_wmask", mem_wmask, 0);
    chk("reset instret", instret_cnt, 0);
    chk("reset mispredict", mispredict_cnt, 0);

    // Idle with stray mem_done: no ack, no state change.
    #4;
    chk("idle ack", commit_ack, 0);
    tick();
    mem_done = 1'b0;
    chk("idle mem_req", mem_req, 0);
    chk("idle instret", instret_cnt, 0);

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a store: aborted, not acked, counters cleared.
    drive(mkv(OP_SW, 5'd0, 32'h11112222, 4'd1, 32'h0, 32'h4000, 32'h0, 1'b0, 1'b0,
              0, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 32'h11112222));
    #4;
    tick();
    chk("midstore mem_req", mem_req, 1);
    rst = 1'b1; mem_done = 1'b1;
    #4;
    chk("midstore rst ack", commit_ack, 0);
    tick();
    rst = 1'b0; mem_done = 1'b0; commit_valid = 1'b0;
    m_instret = 32'd0; m_mispred = 32'd0; m_redirect = 32'd0;
    chk("midstore mem_req after rst", mem_req, 0);
    chk("midstore instret", instret_cnt, 0);
    chk("midstore mispredict", mispredict_cnt, 0);
    chk("midstore mem_addr", mem_addr, 0);
    apply(tbl[0], "post-store-reset idle");

    // Reset during the flush cycle.
    drive(tbl[3]);
    #4;
    chk("midflush ack", commit_ack, 1);
    tick();
    chk("midflush flush", flush, 1);
    rst = 1'b1; commit_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_instret = 32'd0; m_mispred = 32'd0; m_redirect = 32'd0;
    chk("midflush flush after rst", flush, 0);
    chk("midflush redirect", redirect_pc, 0);
    chk("midflush mispredict", mispredict_cnt, 0);

    // Randomized stream with idle gaps and stray mem_done pulses.
    for (int n = 0; n < 300; n++) begin
      apply(gen(), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        mem_done = 1'($urandom);
        #4;
        chk("rnd gap ack", commit_ack, 0);
        tick();
        mem_done = 1'b0;
        chk("rnd gap mem_req", mem_req, 0);
        chk("rnd gap instret", instret_cnt, m_instret);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 The block SHALL have parameters: ROB_ID_WIDTH, default 4, ROB index width; OP_WIDTH, default 6, op code width; XLEN, default 32, data/address width.
REQ-002 The block SHALL have clk  in  1  clock; all state updates on the rising edge.
REQ-003 The block SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have commit_valid  in  1  ROB head present and ready.
REQ-005 The block SHALL have commit_id  in  ROB_ID_WIDTH; commit_op  in  OP_WIDTH; commit_rd  in  5; commit_value  in  XLEN. These carry the head entry fields.
REQ-006 The block SHALL have commit_pc, commit_addr, commit_pred_target  in  XLEN, and commit_pred, commit_outcome  in  1. These carry head PC, computed target/store address, predicted target, prediction, and actual outcome.
REQ-007 The block SHALL have commit_ack  out  1  retire head this cycle.
REQ-008 The block SHALL have the register-file write port: rf_we  out  1; rf_waddr  out  5; rf_wdata  out  XLEN; rf_wrob_id  out  ROB_ID_WIDTH (rename tag to clear).
REQ-009 The block SHALL have the store port: mem_req  out  1; mem_addr  out  XLEN; mem_wdata  out  XLEN; mem_wmask  out  4; mem_done  in  1.
REQ-010 The block SHALL have flush  out  1 and redirect_pc  out  XLEN: pipeline flush and the new fetch PC.
REQ-011 The block SHALL have instret_cnt and mispredict_cnt  out  32 each, as retirement statistics.

Function
REQ-012 The block SHALL implement FSM states IDLE, STORE, FLUSH.
REQ-013 The block SHALL classify ops using the shared op definitions: branch = BEQ/BNE/BLT/BGE/BLTU/BGEU; store = SB/SH/SW; JALR; every other op is a register-writing op.
REQ-014 In IDLE with commit_valid and a non-store op, commit_ack SHALL be 1 combinationally in the same cycle.
REQ-015 rf_we SHALL be 1 only when commit_ack=1, the op is not a branch or store, and commit_rd!=0. In that case rf_waddr=commit_rd, rf_wdata=commit_value, rf_wrob_id=commit_id.
REQ-016 In IDLE with commit_valid and a store op, commit_ack SHALL be 0, and the next edge SHALL enter STORE with mem_req=1 registered.
REQ-017 The store registers SHALL be loaded at that edge as follows: mem_addr=commit_addr. SW: mem_wmask=4'b1111, mem_wdata=value. SH: mem_wmask=4'b0011<<(2*addr[1]), mem_wdata=value<<(16*addr[1]). SB: mem_wmask=4'b0001<<addr[1:0], mem_wdata=value<<(8*addr[1:0]).
REQ-018 In STORE, mem_req and the store registers SHALL hold stable until mem_done=1.
REQ-019 On the mem_done cycle, commit_ack SHALL be 1 combinationally, and the next edge SHALL return to IDLE with mem_req=0.
REQ-020 mem_done SHALL be ignored outside STORE.
REQ-021 A branch SHALL be mispredicted if pred!=outcome, or if outcome=1 and pred_target!=addr.
REQ-022 A JALR SHALL be mispredicted if pred=0 or pred_target!=addr.
REQ-023 A mispredicted op SHALL still be acked, with its rf write for JALR, in the same cycle.
REQ-024 After a mispredicted ack, the next edge SHALL enter FLUSH with flush=1 registered and redirect_pc = addr if taken, else pc+4 (modulo 2^XLEN).
REQ-025 FLUSH SHALL last exactly one cycle, with commit_ack=0 and rf_we=0, then return to IDLE with flush=0. redirect_pc SHALL hold its value until the next flush.
REQ-026 instret_cnt SHALL increment by 1 on every commit_ack cycle.
REQ-027 mispredict_cnt SHALL increment by 1 on every mispredicted ack.
REQ-028 Both counters SHALL wrap modulo 2^32.
REQ-029 commit_valid=0 in IDLE SHALL produce no outputs and no state change.
REQ-030 At most one instruction SHALL retire per cycle.
REQ-031 The block SHALL NOT depend on the head fields changing while STORE is active; the head is stable until ack.

Reset
REQ-032 rst SHALL override all other inputs. On the edge where rst=1: state=IDLE, mem_req=0, flush=0, redirect_pc=0, mem_addr=0, mem_wdata=0, mem_wmask=0, instret_cnt=0, mispredict_cnt=0.
REQ-033 While rst=1, commit_ack and rf_we SHALL be 0.
REQ-034 rst asserted in STORE or FLUSH SHALL abort the operation: mem_req or flush is 0 from the next cycle, and the pending store is not acked.

Verification
REQ-035 The bench SHALL cover ADD retire: commit_valid=1, op=ADD, rd=5, value=0x1234, id=3 -> same cycle commit_ack=1, rf_we=1, rf_waddr=5, rf_wdata=0x1234, rf_wrob_id=3, instret_cnt+1.
REQ-036 The bench SHALL cover rd=0: ADD with rd=0 -> commit_ack=1, rf_we=0.
REQ-037 The bench SHALL cover a byte store with delayed completion: SB, addr=0x1002, value=0xAB, mem_done after 3 cycles -> mem_req=1 for 3 cycles, mem_wmask=0100, mem_wdata=0x00AB0000; commit_ack=1 only on the mem_done cycle; no rf write.
REQ-038 The bench SHALL cover a taken-branch mispredict: BEQ at pc=0x100, pred=0, outcome=1, addr=0x140 -> ack, no rf write; next cycle flush=1, redirect_pc=0x140, mispredict_cnt=1; following cycle flush=0 and commit_ack=0 during the flush cycle.
REQ-039 The bench SHALL cover a JALR target mispredict: JALR at pc=0x200, rd=1, value=0x204, pred=1, pred_target=0x300, addr=0x310 -> rf write x1=0x204 with ack; next cycle flush=1, redirect_pc=0x310.
REQ-040 The bench SHALL cover reset mid-store: rst asserted during STORE -> next cycle mem_req=0, state IDLE, counters 0, no commit_ack.
